// File: rtl/axi4_cmd_arbiter_if.sv
// ============================================================================
// Module   : axi4_cmd_arbiter_if
// Brief    : Requester and master-side command bundle for axi4_cmd_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_cmd_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              c0_valid;
    logic              c0_ready;
    logic              c0_wr;
    logic [ADDR_W-1:0] c0_addr;
    logic [7:0]        c0_burstlen;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_rsp_valid;
    logic              c0_rsp_err;
    logic [DATA_W-1:0] c0_rdata;

    logic              c1_valid;
    logic              c1_ready;
    logic              c1_wr;
    logic [ADDR_W-1:0] c1_addr;
    logic [7:0]        c1_burstlen;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_rsp_valid;
    logic              c1_rsp_err;
    logic [DATA_W-1:0] c1_rdata;

    logic              m_write;
    logic              m_read;
    logic [ADDR_W-1:0] m_address;
    logic [7:0]        m_burstlen;
    logic [DATA_W-1:0] m_write_data;
    logic [DATA_W-1:0] m_read_data;
    logic              m_done;

    // Arbiter side
    modport slave (
        input  c0_valid, c0_wr, c0_addr, c0_burstlen, c0_wdata,
        output c0_ready, c0_rsp_valid, c0_rsp_err, c0_rdata,
        input  c1_valid, c1_wr, c1_addr, c1_burstlen, c1_wdata,
        output c1_ready, c1_rsp_valid, c1_rsp_err, c1_rdata,
        output m_write, m_read, m_address, m_burstlen, m_write_data,
        input  m_read_data, m_done
    );

    // Requesters plus the downstream AXI4 master block
    modport master (
        output c0_valid, c0_wr, c0_addr, c0_burstlen, c0_wdata,
        input  c0_ready, c0_rsp_valid, c0_rsp_err, c0_rdata,
        output c1_valid, c1_wr, c1_addr, c1_burstlen, c1_wdata,
        input  c1_ready, c1_rsp_valid, c1_rsp_err, c1_rdata,
        input  m_write, m_read, m_address, m_burstlen, m_write_data,
        output m_read_data, m_done
    );
endinterface

`default_nettype wire

// File: rtl/axi4_cmd_arbiter.sv
// ============================================================================
// Module   : axi4_cmd_arbiter
// Brief    : Round-robin sharing of one AXI4 master command port between two
//            requesters, with legality screening and completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_cmd_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic         m_axi_aclk,
    input  wire logic         m_axi_aresetn,
    axi4_cmd_arbiter_if.slave bus
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_ISSUE    = 2'd1;
    localparam logic [1:0]  c_WAIT     = 2'd2;
    localparam logic [1:0]  c_RESP     = 2'd3;
    localparam int          c_BYTES    = DATA_W / 8;
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_prio;
    logic              r_gnt;
    logic              r_wr;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [DATA_W-1:0] r_wdata;
    logic              r_c0_err;
    logic              r_c1_err;
    logic [DATA_W-1:0] r_c0_rdata;
    logic [DATA_W-1:0] r_c1_rdata;

    logic              w_gnt;
    logic              w_hs;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_len;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [15:0]       w_end;
    logic              w_illegal;
    logic              w_wait_exit;
    logic              w_rsp_load;
    logic              w_rsp_idx;
    logic              w_rsp_err;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_m_write;
    logic              w_m_read;
    logic              w_c0_ready;
    logic              w_c1_ready;
    logic              w_c0_rsp_valid;
    logic              w_c1_rsp_valid;

    // r_prio names the requester that wins when both are valid
    always_comb begin
        w_gnt = bus.c1_valid;
        if (bus.c0_valid && bus.c1_valid) begin
            w_gnt = r_prio;
        end
    end

    // Ready is forced low while reset is held so no handshake is seen
    assign w_hs        = (r_state == c_IDLE) && (bus.c0_valid || bus.c1_valid) && m_axi_aresetn;
    assign w_sel_wr    = w_gnt ? bus.c1_wr       : bus.c0_wr;
    assign w_sel_addr  = w_gnt ? bus.c1_addr     : bus.c0_addr;
    assign w_sel_len   = w_gnt ? bus.c1_burstlen : bus.c0_burstlen;
    assign w_sel_wdata = w_gnt ? bus.c1_wdata    : bus.c0_wdata;

    assign w_end     = 16'(w_sel_addr[11:0]) + (16'(w_sel_len) + 16'd1) * 16'(c_BYTES);
    assign w_illegal = ((w_sel_addr & ADDR_W'(c_BYTES - 1)) != '0) || (w_end > 16'd4096);

    assign w_wait_exit = (r_state == c_WAIT) && (bus.m_done || (r_cnt == c_TMO_LAST));

    // Responses are written on the edge entering RESP; m_done beats the timeout
    assign w_rsp_load = (w_hs && w_illegal) || w_wait_exit;
    assign w_rsp_idx  = (r_state == c_IDLE) ? w_gnt : r_gnt;
    assign w_rsp_err  = (r_state == c_IDLE) ? 1'b1 : !bus.m_done;
    assign w_rsp_data = ((r_state == c_WAIT) && bus.m_done && !r_wr) ? bus.m_read_data : '0;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_hs) w_state_nxt = w_illegal ? c_RESP : c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT:  if (w_wait_exit) w_state_nxt = c_RESP;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_m_write      = (r_state == c_ISSUE) && r_wr;
        w_m_read       = (r_state == c_ISSUE) && !r_wr;
        w_c0_ready     = w_hs && !w_gnt;
        w_c1_ready     = w_hs && w_gnt;
        w_c0_rsp_valid = (r_state == c_RESP) && !r_gnt;
        w_c1_rsp_valid = (r_state == c_RESP) && r_gnt;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_prio  <= 1'b0;
            r_gnt   <= 1'b0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_wdata <= '0;
        end else begin
            r_cnt <= (r_state == c_WAIT) ? r_cnt + 16'd1 : 16'd0;
            if (w_hs) begin
                r_gnt  <= w_gnt;
                r_wr   <= w_sel_wr;
                r_prio <= !w_gnt;
                if (!w_illegal) begin
                    r_addr  <= w_sel_addr;
                    r_len   <= w_sel_len;
                    r_wdata <= w_sel_wdata;
                end
            end else if (w_wait_exit) begin
                r_addr  <= '0;
                r_len   <= '0;
                r_wdata <= '0;
            end
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_c0_err   <= 1'b0;
            r_c1_err   <= 1'b0;
            r_c0_rdata <= '0;
            r_c1_rdata <= '0;
        end else if (w_rsp_load) begin
            if (w_rsp_idx) begin
                r_c1_err   <= w_rsp_err;
                r_c1_rdata <= w_rsp_data;
            end else begin
                r_c0_err   <= w_rsp_err;
                r_c0_rdata <= w_rsp_data;
            end
        end
    end

    assign bus.c0_ready     = w_c0_ready;
    assign bus.c1_ready     = w_c1_ready;
    assign bus.c0_rsp_valid = w_c0_rsp_valid;
    assign bus.c1_rsp_valid = w_c1_rsp_valid;
    assign bus.c0_rsp_err   = r_c0_err;
    assign bus.c1_rsp_err   = r_c1_err;
    assign bus.c0_rdata     = r_c0_rdata;
    assign bus.c1_rdata     = r_c1_rdata;
    assign bus.m_write      = w_m_write;
    assign bus.m_read       = w_m_read;
    assign bus.m_address    = r_addr;
    assign bus.m_burstlen   = r_len;
    assign bus.m_write_data = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_axi4_cmd_arbiter.sv
// ============================================================================
// Module   : tb_axi4_cmd_arbiter
// Brief    : Directed self-checking bench for axi4_cmd_arbiter (timeout = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_cmd_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   e;

    axi4_cmd_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus ();

    axi4_cmd_arbiter #(
        .ADDR_W         (24),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input int n, input logic wr, input logic [23:0] addr,
                       input logic [7:0] len, input logic [31:0] wd);
        if (n == 0) begin
            bus.c0_valid = 1'b1; bus.c0_wr = wr; bus.c0_addr = addr;
            bus.c0_burstlen = len; bus.c0_wdata = wd;
        end else begin
            bus.c1_valid = 1'b1; bus.c1_wr = wr; bus.c1_addr = addr;
            bus.c1_burstlen = len; bus.c1_wdata = wd;
        end
    endtask

    task automatic drop();
        bus.c0_valid = 1'b0; bus.c0_wdata = '0; bus.c0_addr = '0;
        bus.c1_valid = 1'b0; bus.c1_wdata = '0; bus.c1_addr = '0;
    endtask

    initial begin
        bus.c0_valid = 1'b1; bus.c0_wr = 1'b0; bus.c0_addr = '0; bus.c0_burstlen = '0; bus.c0_wdata = '0;
        bus.c1_valid = 1'b1; bus.c1_wr = 1'b0; bus.c1_addr = '0; bus.c1_burstlen = '0; bus.c1_wdata = '0;
        bus.m_read_data = '0;
        bus.m_done = 1'b0;

        // Reset state, with both requesters already valid
        #2;
        chk("rst_c0_ready", bus.c0_ready, 0);
        chk("rst_c1_ready", bus.c1_ready, 0);
        chk("rst_m_write", bus.m_write, 0);
        chk("rst_m_read", bus.m_read, 0);
        chk("rst_m_address", bus.m_address, 0);
        chk("rst_m_burstlen", bus.m_burstlen, 0);
        chk("rst_m_write_data", bus.m_write_data, 0);
        chk("rst_c0_rsp_valid", bus.c0_rsp_valid, 0);
        chk("rst_c1_rsp_valid", bus.c1_rsp_valid, 0);
        chk("rst_c0_rsp_err", bus.c0_rsp_err, 0);
        chk("rst_c0_rdata", bus.c0_rdata, 0);
        chk("rst_c1_rdata", bus.c1_rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        drop();

        // Single legal write from c0, m_done at T+5
        req(0, 1'b1, 24'h000004, 8'h00, 32'h55555555);
        #1;
        chk("t1_c0_ready", bus.c0_ready, 1);
        chk("t1_c1_ready", bus.c1_ready, 0);
        tick();
        drop();
        chk("t1_m_write", bus.m_write, 1);
        chk("t1_m_read", bus.m_read, 0);
        chk("t1_m_address", bus.m_address, 32'h000004);
        chk("t1_m_write_data", bus.m_write_data, 32'h55555555);
        chk("t1_m_burstlen", bus.m_burstlen, 0);
        tick();
        chk("t1_m_write_once", bus.m_write, 0);
        chk("t1_addr_hold", bus.m_address, 32'h000004);
        tick();
        tick();
        tick();
        bus.m_done = 1'b1; bus.m_read_data = 32'hDEADBEEF;
        tick();
        bus.m_done = 1'b0; bus.m_read_data = '0;
        chk("t1_c0_rsp_valid", bus.c0_rsp_valid, 1);
        chk("t1_c0_rsp_err", bus.c0_rsp_err, 0);
        chk("t1_c0_rdata_write", bus.c0_rdata, 0);
        chk("t1_c1_rsp_valid", bus.c1_rsp_valid, 0);
        chk("t1_addr_cleared", bus.m_address, 0);
        tick();
        chk("t1_rsp_one_cycle", bus.c0_rsp_valid, 0);

        // Burst read from c1
        req(1, 1'b0, 24'h000100, 8'h0F, 32'h0);
        #1;
        chk("t2_c1_ready", bus.c1_ready, 1);
        chk("t2_c0_ready", bus.c0_ready, 0);
        tick();
        drop();
        chk("t2_m_read", bus.m_read, 1);
        chk("t2_m_write", bus.m_write, 0);
        chk("t2_m_address", bus.m_address, 32'h000100);
        chk("t2_m_burstlen", bus.m_burstlen, 32'h0F);
        tick();
        chk("t2_m_read_once", bus.m_read, 0);
        bus.m_done = 1'b1; bus.m_read_data = 32'h0000000F;
        tick();
        bus.m_done = 1'b0; bus.m_read_data = '0;
        chk("t2_c1_rsp_valid", bus.c1_rsp_valid, 1);
        chk("t2_c1_rsp_err", bus.c1_rsp_err, 0);
        chk("t2_c1_rdata", bus.c1_rdata, 32'h0000000F);
        chk("t2_c0_rsp_valid", bus.c0_rsp_valid, 0);
        chk("t2_c0_rdata_unchanged", bus.c0_rdata, 0);
        tick();
        chk("t2_c1_rsp_end", bus.c1_rsp_valid, 0);
        chk("t2_c1_rdata_hold", bus.c1_rdata, 32'h0000000F);

        // Contention: both continuously valid, grants alternate 0,1,0,1,0,1
        req(0, 1'b0, 24'h000200, 8'h01, 32'h0);
        req(1, 1'b0, 24'h000300, 8'h02, 32'h0);
        for (int i = 0; i < 6; i++) begin
            e = i % 2;
            #1;
            chk("t3_c0_ready", bus.c0_ready, (e == 0) ? 1 : 0);
            chk("t3_c1_ready", bus.c1_ready, (e == 1) ? 1 : 0);
            tick();
            chk("t3_m_read", bus.m_read, 1);
            chk("t3_m_address", bus.m_address, (e == 0) ? 32'h000200 : 32'h000300);
            chk("t3_busy_ready", bus.c0_ready | bus.c1_ready, 0);
            tick();
            chk("t3_no_pulse_wait", bus.m_read | bus.m_write, 0);
            bus.m_done = 1'b1; bus.m_read_data = 32'(i);
            tick();
            bus.m_done = 1'b0; bus.m_read_data = '0;
            chk("t3_c0_rsp_valid", bus.c0_rsp_valid, (e == 0) ? 1 : 0);
            chk("t3_c1_rsp_valid", bus.c1_rsp_valid, (e == 1) ? 1 : 0);
            chk("t3_rdata", (e == 0) ? bus.c0_rdata : bus.c1_rdata, 32'(i));
            tick();
        end
        drop();

        // 4 KB boundary: end exactly at 4096 is legal
        req(0, 1'b1, 24'h000FC0, 8'h0F, 32'h11111111);
        #1;
        chk("t4a_c0_ready", bus.c0_ready, 1);
        tick();
        drop();
        chk("t4a_m_write", bus.m_write, 1);
        chk("t4a_m_address", bus.m_address, 32'h000FC0);
        tick();
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        chk("t4a_c0_rsp_valid", bus.c0_rsp_valid, 1);
        chk("t4a_c0_rsp_err", bus.c0_rsp_err, 0);
        tick();

        // Crosses 4 KB (sum 4100): rejected, response at T+1, no master pulse
        req(0, 1'b1, 24'h000FC4, 8'h0F, 32'h22222222);
        #1;
        chk("t4b_c0_ready", bus.c0_ready, 1);
        tick();
        drop();
        chk("t4b_no_m_write", bus.m_write, 0);
        chk("t4b_no_m_read", bus.m_read, 0);
        chk("t4b_c0_rsp_valid", bus.c0_rsp_valid, 1);
        chk("t4b_c0_rsp_err", bus.c0_rsp_err, 1);
        chk("t4b_c0_rdata", bus.c0_rdata, 0);
        chk("t4b_m_address", bus.m_address, 0);
        tick();
        chk("t4b_rsp_end", bus.c0_rsp_valid, 0);
        chk("t4b_err_hold", bus.c0_rsp_err, 1);
        chk("t4b_no_pulse_later", bus.m_write | bus.m_read, 0);

        // Misaligned address
        req(1, 1'b0, 24'h000002, 8'h00, 32'h0);
        tick();
        drop();
        chk("t4c_no_m_read", bus.m_read, 0);
        chk("t4c_c1_rsp_valid", bus.c1_rsp_valid, 1);
        chk("t4c_c1_rsp_err", bus.c1_rsp_err, 1);
        chk("t4c_c1_rdata", bus.c1_rdata, 0);
        tick();

        // Last word of a 4 KB page, single beat (sum 4096): legal
        req(1, 1'b0, 24'h000FFC, 8'h00, 32'h0);
        tick();
        drop();
        chk("t4d_m_read", bus.m_read, 1);
        chk("t4d_m_address", bus.m_address, 32'h000FFC);
        tick();
        bus.m_done = 1'b1; bus.m_read_data = 32'h12345678;
        tick();
        bus.m_done = 1'b0; bus.m_read_data = '0;
        chk("t4d_c1_rsp_valid", bus.c1_rsp_valid, 1);
        chk("t4d_c1_rsp_err", bus.c1_rsp_err, 0);
        chk("t4d_c1_rdata", bus.c1_rdata, 32'h12345678);
        tick();

        // Timeout: WAIT entered at T+2, error response at T+10
        req(0, 1'b1, 24'h000010, 8'h00, 32'hCAFE0000);
        tick();
        drop();
        chk("t5a_m_write", bus.m_write, 1);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("t5a_no_rsp_in_wait", bus.c0_rsp_valid, 0);
        end
        tick();
        chk("t5a_c0_rsp_valid", bus.c0_rsp_valid, 1);
        chk("t5a_c0_rsp_err", bus.c0_rsp_err, 1);
        chk("t5a_c0_rdata", bus.c0_rdata, 0);
        chk("t5a_addr_cleared", bus.m_address, 0);
        tick();
        bus.m_done = 1'b1; bus.m_read_data = 32'hBAD0BAD0;
        tick();
        bus.m_done = 1'b0; bus.m_read_data = '0;
        chk("t5a_late_done_c0", bus.c0_rsp_valid, 0);
        chk("t5a_late_done_c1", bus.c1_rsp_valid, 0);
        chk("t5a_late_done_pulse", bus.m_write | bus.m_read, 0);
        chk("t5a_late_done_rdata", bus.c0_rdata, 0);

        // m_done on the expiry cycle (T+9) wins over the timeout
        req(0, 1'b0, 24'h000020, 8'h00, 32'h0);
        tick();
        drop();
        chk("t5b_m_read", bus.m_read, 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
        end
        tick();
        chk("t5b_no_rsp_yet", bus.c0_rsp_valid, 0);
        bus.m_done = 1'b1; bus.m_read_data = 32'hA5A5A5A5;
        tick();
        bus.m_done = 1'b0; bus.m_read_data = '0;
        chk("t5b_c0_rsp_valid", bus.c0_rsp_valid, 1);
        chk("t5b_c0_rsp_err", bus.c0_rsp_err, 0);
        chk("t5b_c0_rdata", bus.c0_rdata, 32'hA5A5A5A5);
        tick();

        // Asynchronous reset while in WAIT
        req(1, 1'b0, 24'h000040, 8'h00, 32'h0);
        tick();
        drop();
        chk("t6_m_read", bus.m_read, 1);
        tick();
        tick();
        chk("t6_addr_in_wait", bus.m_address, 32'h000040);
        bus.c0_valid = 1'b1;
        bus.c1_valid = 1'b1; bus.c1_addr = 24'h000040;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_address", bus.m_address, 0);
        chk("t6_rst_m_read", bus.m_read, 0);
        chk("t6_rst_c0_ready", bus.c0_ready, 0);
        chk("t6_rst_c1_ready", bus.c1_ready, 0);
        chk("t6_rst_c0_rdata", bus.c0_rdata, 0);
        chk("t6_rst_c1_rsp_valid", bus.c1_rsp_valid, 0);
        tick();
        chk("t6_no_rsp_in_rst", bus.c1_rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        bus.c0_valid = 1'b0;
        #1;
        chk("t6_c1_ready", bus.c1_ready, 1);
        tick();
        drop();
        chk("t6_m_read_after", bus.m_read, 1);
        chk("t6_m_address_after", bus.m_address, 32'h000040);
        tick();
        bus.m_done = 1'b1; bus.m_read_data = 32'h00000077;
        tick();
        bus.m_done = 1'b0; bus.m_read_data = '0;
        chk("t6_c1_rsp_valid", bus.c1_rsp_valid, 1);
        chk("t6_c1_rdata", bus.c1_rdata, 32'h00000077);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
